// File: rtl/aes128_dec_round_ctrl.sv
// AES-128 decryption round sequencer: key add with key NR, then NR inverse rounds via an external datapath.
// Latency 2+2*NR edges from accept to out_valid; in_ready only in IDLE, result held in DONE until out_ready.
module aes128_dec_round_ctrl #(
    parameter int NR   = 10,
    parameter int KA_W = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [127:0]    in_data,
    output logic [KA_W-1:0] rk_addr,
    input  logic [127:0]    rk_data,
    output logic [127:0]    rnd_state,
    output logic            rnd_last,
    input  logic [127:0]    rnd_result,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [127:0]    out_data,
    output logic            busy,
    output logic [3:0]      round
);

    typedef enum logic [2:0] {
        IDLE,
        KFETCH,
        KADD,
        RFETCH,
        RAPPLY,
        DONE
    } state_t;

    localparam logic [3:0]      NR_R  = 4'(NR);
    localparam logic [KA_W-1:0] NR_KA = KA_W'(NR);

    state_t          r_fsm;
    state_t          w_fsm_nxt;
    logic [127:0]    r_state;
    logic [127:0]    r_ct;
    logic [3:0]      r_round;
    logic [KA_W-1:0] r_rk_addr;
    logic            w_final;
    logic [KA_W-1:0] w_rk_nxt;

    assign w_final  = (r_round == NR_R);
    // Address for the round after this one; registered so the key arrives in the following RAPPLY.
    assign w_rk_nxt = NR_KA - KA_W'(r_round + 4'd1);

    always_comb begin
        w_fsm_nxt = r_fsm;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        rnd_last  = 1'b0;
        case (r_fsm)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) w_fsm_nxt = KFETCH;
            end
            KFETCH:  w_fsm_nxt = KADD;
            KADD:    w_fsm_nxt = RFETCH;
            RFETCH:  w_fsm_nxt = RAPPLY;
            RAPPLY: begin
                rnd_last  = w_final;
                w_fsm_nxt = w_final ? DONE : RFETCH;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) w_fsm_nxt = IDLE;
            end
            default: w_fsm_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fsm     <= IDLE;
            r_state   <= '0;
            r_ct      <= '0;
            r_round   <= '0;
            r_rk_addr <= '0;
        end else begin
            r_fsm <= w_fsm_nxt;
            case (r_fsm)
                IDLE: begin
                    if (in_valid) begin
                        r_ct      <= in_data;
                        r_rk_addr <= NR_KA;
                    end
                end
                KADD: begin
                    r_state   <= r_ct ^ rk_data;
                    r_round   <= 4'd1;
                    r_rk_addr <= NR_KA - KA_W'(1);
                end
                RAPPLY: begin
                    r_state <= rnd_result;
                    if (w_final) begin
                        r_round <= '0;
                    end else begin
                        r_round   <= r_round + 4'd1;
                        r_rk_addr <= w_rk_nxt;
                    end
                end
                default: ;
            endcase
        end
    end

    assign rk_addr   = r_rk_addr;
    assign rnd_state = r_state;
    assign out_data  = r_state;
    assign round     = r_round;

endmodule

// File: tb/tb_aes128_dec_round_ctrl.sv
// Bench for aes128_dec_round_ctrl: models the key store and inverse-round datapath, checks FIPS-197 vectors.
module tb_aes128_dec_round_ctrl;

    logic         clk = 1'b0;
    logic         rst, in_valid, in_ready, out_valid, out_ready, busy, rnd_last;
    logic [127:0] in_data, rk_data, rnd_state, rnd_result, out_data;
    logic [3:0]   rk_addr, round;
    logic [127:0] rks [0:10];
    int           cyc = 0;
    int           n_chk = 0;
    int           n_fail = 0;

    always #5 clk = ~clk;

    aes128_dec_round_ctrl #(.NR(10), .KA_W(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .rk_addr(rk_addr), .rk_data(rk_data), .rnd_state(rnd_state), .rnd_last(rnd_last),
        .rnd_result(rnd_result), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .busy(busy), .round(round)
    );

    // ---------------- AES reference pieces ----------------
    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction

    // a^254 is the multiplicative inverse in GF(2^8), with 0 mapping to 0
    function automatic logic [7:0] ginv(input logic [7:0] a);
        logic [7:0] r;
        r = a;
        for (int i = 0; i < 6; i++) r = gmul(gmul(r, r), a);
        return gmul(r, r);
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [15:0] d;
        d = {b, b} << n;
        return d[15:8];
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] i;
        i = ginv(a);
        return i ^ rotl8(i, 1) ^ rotl8(i, 2) ^ rotl8(i, 3) ^ rotl8(i, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] a);
        return ginv(rotl8(a, 1) ^ rotl8(a, 3) ^ rotl8(a, 6) ^ 8'h05);
    endfunction

    function automatic logic [127:0] inv_round(input logic [127:0] s, input logic [127:0] k, input logic last);
        logic [127:0] t;
        logic [7:0]   a0, a1, a2, a3;
        t = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                t[127-8*(4*c+r) -: 8] = inv_sbox(s[127-8*(4*((c-r+4)%4)+r) -: 8]);
        t = t ^ k;
        if (!last) begin
            for (int c = 0; c < 4; c++) begin
                a0 = t[127-32*c -: 8];
                a1 = t[119-32*c -: 8];
                a2 = t[111-32*c -: 8];
                a3 = t[103-32*c -: 8];
                t[127-32*c -: 8] = gmul(a0,8'h0e) ^ gmul(a1,8'h0b) ^ gmul(a2,8'h0d) ^ gmul(a3,8'h09);
                t[119-32*c -: 8] = gmul(a0,8'h09) ^ gmul(a1,8'h0e) ^ gmul(a2,8'h0b) ^ gmul(a3,8'h0d);
                t[111-32*c -: 8] = gmul(a0,8'h0d) ^ gmul(a1,8'h09) ^ gmul(a2,8'h0e) ^ gmul(a3,8'h0b);
                t[103-32*c -: 8] = gmul(a0,8'h0b) ^ gmul(a1,8'h0d) ^ gmul(a2,8'h09) ^ gmul(a3,8'h0e);
            end
        end
        return t;
    endfunction

    task automatic load_key(input logic [127:0] key);
        logic [31:0] w [0:43];
        logic [31:0] tmp;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {sbox(tmp[23:16]), sbox(tmp[15:8]), sbox(tmp[7:0]), sbox(tmp[31:24])} ^ {rc, 24'h0};
                rc  = xt(rc);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int r = 0; r < 11; r++) rks[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    // Synchronous key store and combinational inverse-round datapath
    always_ff @(posedge clk) rk_data <= (rk_addr <= 4'd10) ? rks[rk_addr] : '0;
    assign rnd_result = inv_round(rnd_state, rk_data, rnd_last);

    // ---------------- bench helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chki(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic offer(input logic [127:0] ct, output int t_acc);
        int g;
        g = 0;
        while (!in_ready && g < 60) begin
            tick();
            g++;
        end
        in_data  = ct;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        t_acc    = cyc;
        chki("accepted", int'(busy), 1);
    endtask

    task automatic wait_out(input logic [127:0] exp, input int t_acc, input bit trace);
        int         lg[$];
        int         nlast, last_n, g;
        logic [3:0] lastaddr;
        bit         ok;
        lastaddr = 4'hf;
        nlast    = 0;
        last_n   = -1;
        g        = 0;
        while (!out_valid && g < 60) begin
            if (trace && rk_addr != lastaddr) begin
                lg.push_back(int'(rk_addr));
                lastaddr = rk_addr;
            end
            if (rnd_last) begin
                nlast++;
                last_n = cyc - t_acc;
                chki("rnd_last_round", int'(round), 10);
            end
            tick();
            g++;
        end
        chki("latency", cyc - t_acc, 22);
        chk("out_data", out_data, exp);
        chki("in_ready_in_done", int'(in_ready), 0);
        chki("rnd_last_count", nlast, 1);
        chki("rnd_last_cycle", last_n, 21);
        if (trace) begin
            ok = (lg.size() == 11);
            for (int i = 0; i < lg.size(); i++) if (lg[i] != 10 - i) ok = 1'b0;
            chki("rk_addr_order", int'(ok), 1);
        end
    endtask

    task automatic consume();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chki("out_valid_fall", int'(out_valid), 0);
        chki("idle_after_consume", int'(busy), 0);
    endtask

    typedef struct {
        logic [127:0] key;
        logic [127:0] ct;
        logic [127:0] pt;
    } vec_t;

    vec_t vecs [3];

    initial begin
        int t, g;

        vecs[0] = '{128'h000102030405060708090a0b0c0d0e0f,
                    128'h69c4e0d86a7b0430d8cdb78070b4c55a,
                    128'h00112233445566778899aabbccddeeff};
        vecs[1] = '{128'h2b7e151628aed2a6abf7158809cf4f3c,
                    128'h3925841d02dc09fbdc118597196a0b32,
                    128'h3243f6a8885a308d313198a2e0370734};
        vecs[2] = '{128'h0,
                    128'h66e94bd4ef8a2c3b884cfa59ca342b2e,
                    128'h0};

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_data   = '0;
        load_key(vecs[0].key);
        tick();
        tick();
        rst = 1'b0;
        #1;
        chki("rst_in_ready", int'(in_ready), 1);
        chki("rst_busy", int'(busy), 0);
        chki("rst_out_valid", int'(out_valid), 0);
        chki("rst_round", int'(round), 0);
        chki("rst_rk_addr", int'(rk_addr), 0);
        chki("rst_rnd_last", int'(rnd_last), 0);
        chk("rst_out_data", out_data, 128'h0);

        for (int v = 0; v < 3; v++) begin
            load_key(vecs[v].key);
            offer(vecs[v].ct, t);
            wait_out(vecs[v].pt, t, 1'b1);
            consume();
        end

        // Output backpressure with a competing input offer
        load_key(vecs[0].key);
        offer(vecs[0].ct, t);
        wait_out(vecs[0].pt, t, 1'b0);
        in_data  = vecs[1].ct;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chki("bp_out_valid", int'(out_valid), 1);
            chk("bp_out_data", out_data, vecs[0].pt);
            chki("bp_in_ready", int'(in_ready), 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chki("bp_release_busy", int'(busy), 0);
        chki("bp_release_in_ready", int'(in_ready), 1);
        tick();
        chki("bp_no_new_block", int'(busy), 0);

        // in_valid pulsed mid-block is ignored
        offer(vecs[0].ct, t);
        g = 0;
        while (round != 4'd4 && g < 60) begin
            tick();
            g++;
        end
        chki("reach_round4", int'(round), 4);
        in_data  = vecs[1].ct;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        wait_out(vecs[0].pt, t, 1'b0);
        consume();
        tick();
        chki("no_second_block", int'(busy), 0);

        // Reset at round 6, then a clean block
        offer(vecs[0].ct, t);
        g = 0;
        while (round != 4'd6 && g < 60) begin
            tick();
            g++;
        end
        chki("reach_round6", int'(round), 6);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chki("mid_rst_busy", int'(busy), 0);
        chki("mid_rst_out_valid", int'(out_valid), 0);
        chki("mid_rst_round", int'(round), 0);
        chki("mid_rst_in_ready", int'(in_ready), 1);
        chk("mid_rst_state", out_data, 128'h0);
        offer(vecs[0].ct, t);
        wait_out(vecs[0].pt, t, 1'b1);
        consume();

        // Back-to-back: second block offered while the first is being consumed
        load_key(vecs[1].key);
        offer(vecs[1].ct, t);
        wait_out(vecs[1].pt, t, 1'b1);
        load_key(vecs[2].key);
        in_data   = vecs[2].ct;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chki("b2b_idle_busy", int'(busy), 0);
        chki("b2b_idle_in_ready", int'(in_ready), 1);
        chki("b2b_out_valid", int'(out_valid), 0);
        tick();
        in_valid = 1'b0;
        t = cyc;
        chki("b2b_accepted", int'(busy), 1);
        wait_out(vecs[2].pt, t, 1'b1);
        consume();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/aes128_dec_round_ctrl.md
Name: aes128_dec_round_ctrl

Overview:
Iterative sequencer for the AES-128 decryption datapath. It holds the 128-bit cipher state and fetches round keys 10 down to 0 from an external synchronous round-key store. It feeds the state to an external combinational inverse-round function (InvShiftRows, InvSubBytes, AddRoundKey, then inverse MixColumns unless the round is last) and captures the result. Valid/ready handshakes on both sides connect it to the block-level wrapper.

Parameters:
NR, 10, number of rounds; 10 for AES-128, no other value supported.
KA_W, 4, round-key address width; must satisfy 2^KA_W > NR.

Ports:
clk  in  1  single system clock; all logic is on the rising edge.
rst  in  1  synchronous, active-high reset.
in_valid  in  1  ciphertext offered.
in_ready  out  1  controller can accept a ciphertext.
in_data  in  128  ciphertext; byte [127:120] is s0, column-major.
rk_addr  out  KA_W  round-key index presented to the key store.
rk_data  in  128  round key; valid the cycle after rk_addr is presented (1-cycle read latency).
rnd_state  out  128  current state, driven to the inverse-round datapath.
rnd_last  out  1  high during round NR; datapath bypasses inverse MixColumns.
rnd_result  in  128  combinational datapath result for rnd_state XOR rk_data.
out_valid  out  1  plaintext available.
out_ready  in  1  consumer accepts the plaintext.
out_data  out  128  plaintext (state register).
busy  out  1  high in any state other than IDLE.
round  out  4  current round number, 0..NR.

Behaviour:
- FSM states: IDLE, KFETCH, KADD, RFETCH, RAPPLY, DONE.
- Reset values: state IDLE, state register 0, round 0, rk_addr 0, out_valid 0, busy 0, rnd_last 0. in_ready is 1 once reset deasserts.
- IDLE:
  - in_ready=1.
  - On in_valid, capture in_data and go to KFETCH.
- KFETCH: rk_addr=NR. Next state KADD.
- KADD: state <= captured ciphertext XOR rk_data (key NR); round <= 1. Next state RFETCH.
- RFETCH: rk_addr = NR - round. Next state RAPPLY.
- RAPPLY:
  - state <= rnd_result.
  - rnd_last = (round==NR).
  - If round==NR, go to DONE. Otherwise round <= round+1 and go to RFETCH.
- rk_addr holds its value outside the FETCH states.
- rnd_state always equals the state register.
- DONE:
  - out_valid=1; out_data is stable while stalled.
  - On out_ready, go to IDLE; out_valid falls on the next cycle.
  - in_ready=0 in DONE, so there is no back-to-back overlap.
- Latency: out_valid rises exactly 2+2*NR = 22 rising edges after the accepting edge. Throughput is one block per 24 cycles at minimum.
- in_valid is ignored outside IDLE; in_data is sampled only on the accepting edge.
- Reset mid-operation: the next edge returns to IDLE, drops out_valid and busy, clears round and state, and discards any captured data.
- The round counter never exceeds NR; round = 0 in IDLE, KFETCH and DONE, and round = NR during the final RAPPLY.
- Each rk_addr value 10..0 is issued exactly once per block, in strictly descending order.

Test Plan:
- FIPS-197 C.1: load the key store with the expansion of key 000102030405060708090a0b0c0d0e0f. Send in_data 69c4e0d86a7b0430d8cdb78070b4c55a -> out_data 00112233445566778899aabbccddeeff, with out_valid exactly 22 edges after acceptance.
- Key-address trace: log rk_addr during KFETCH/RFETCH -> sequence 10,9,...,0. rnd_last is high only during round 10's RAPPLY.
- Output backpressure: hold out_ready=0 for 5 cycles in DONE -> out_valid and out_data are stable, in_ready=0, and a new in_valid is not accepted. Release -> IDLE next cycle.
- Input ignored while busy: pulse in_valid with a different ciphertext at round 4 -> result is still the original plaintext and no second block is started.
- Reset at round 6: assert rst for 1 cycle -> next cycle IDLE, busy=0, out_valid=0, round=0. A subsequent C.1 vector decrypts correctly.
- Back-to-back: two blocks, the second offered in the cycle after the first is consumed -> both plaintexts are correct and the second is accepted only once IDLE is re-entered.
